instruction_fetch: RTL and testbench
====================================

# instruction_fetch

- Sequences the instruction memory: owns the program counter, presents it on the memory address port and captures the combinational read data into a registered fetch slot.
- The slot is handed to decode with a valid/ready handshake and supports stall, redirect (branch/jump/trap target) and misaligned-target faulting.
- Sits between `instruction_memory` and the decode stage as the IF stage of the RV32I pipeline.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (must be 4-byte aligned).
- `clk` input 1 — single clock, rising-edge.
- `reset_n` input 1 — asynchronous, active-low reset.
- `fetch_en` input 1 — permits new fetches; low freezes PC and slot contents.
- `imem_addr` output 32 — address to `instruction_memory`; always equals current PC.
- `imem_rd_instr` input 32 — combinational read data for `imem_addr`.
- `redirect_valid` input 1 — one-cycle request to change the fetch stream.
- `redirect_pc` input 32 — target PC accompanying `redirect_valid`.
- `out_valid` output 1 — fetch slot holds a valid instruction.
- `out_ready` input 1 — decode accepts the slot this cycle.
- `out_instr` output 32 — fetched instruction.
- `out_pc` output 32 — PC of `out_instr`.
- `out_pc_plus4` output 32 — `out_pc + 4`, modulo 2^32.
- `fault` output 1 — misaligned redirect target seen; sticky until reset.
- `fault_pc` output 32 — offending `redirect_pc`.
- `fetch_count` output 32 — count of accepted slots (`out_valid & out_ready`); wraps.

## Operation
- **Reset values:**
  - `pc = RESET_PC`, state IDLE.
  - `out_valid = 0`; `out_instr`, `out_pc`, `fault_pc`, `fetch_count` = 0.
  - `out_pc_plus4 = 4`, `fault = 0`.
- **FSM states:**
  - IDLE: no fetch. Goes to RUN on a cycle with `fetch_en = 1`; that same edge performs the first fetch.
  - RUN: fetching. Drops to IDLE when `fetch_en = 0`; an occupied slot is kept and still drains via handshake.
  - FAULT: terminal. `out_valid = 0`, PC frozen. Left only by reset.
- **Fetch slot update, RUN with `fetch_en = 1`:**
  - The slot loads when empty, or when it is consumed this cycle (`out_valid & out_ready`).
  - Load action: `out_instr <= imem_rd_instr`, `out_pc <= pc`, `pc <= pc + 4`, `out_valid <= 1`.
- **Stall:** `out_valid & ~out_ready` holds the slot and PC unchanged. `out_instr`/`out_pc` must not change while `out_valid` is high and unaccepted.
- **Redirect** (highest priority, any state except FAULT):
  - If `redirect_pc[1:0] == 0`: `pc <= redirect_pc`, `out_valid <= 0` (flush), no fetch this edge.
  - If `redirect_pc[1:0] != 0`: enter FAULT, `fault <= 1`, `fault_pc <= redirect_pc`, `out_valid <= 0`, PC unchanged.
- **Redirect + handshake in the same cycle:** the handshake completes (decode took the slot, `fetch_count` increments), then the flush applies.
- **Redirect in IDLE:** PC updates, state stays IDLE.
- **PC arithmetic:** 32-bit, wraps; `32'hFFFF_FFFC + 4 = 0` with no fault.
- **Misalignment check:** applies to `redirect_pc` only. PC is aligned by construction.
- **`fetch_count`:** increments on every `out_valid & out_ready`, wraps at 2^32. Frozen in FAULT.

## Timing
- `imem_addr` is combinational from the PC register, valid the whole cycle.
- Memory read is assumed zero-latency (same-cycle).
- Fetch latency:
  - An instruction at PC appears on `out_*` one edge after the edge where PC was presented with the slot free.
  - First `out_valid` rises at the first edge after reset release with `fetch_en = 1`.
- Throughput: one instruction per cycle with `out_ready` held high.
- Redirect penalty: one bubble. The edge taking the redirect clears `out_valid`; the next edge loads the target instruction.
- Asynchronous reset mid-stream clears the slot immediately. No partial state survives.

## Structure
- Shared package `rv32_pkg`:
  - FSM enum `fetch_state_t {IDLE, RUN, FAULT}`.
  - `XLEN = 32`, `INSTR_BYTES = 4`.
  - `RESET_PC` default.
- No sub-module required; the fetch slot register is inline.
- `instruction_memory` is instantiated by the parent, not inside this block.

## Test plan
Memory model returns `32'hA000_0000 | addr`.
- **Reset then stream:** `fetch_en = 1`, `out_ready = 1` → `out_pc` = 0, 4, 8, 12 on consecutive cycles, `out_instr = 32'hA000_0000 | out_pc`, `fetch_count = 4` after 4 accepts.
- **Stall:** `out_ready = 0` for 3 cycles with slot at PC 8 → `out_instr = 32'hA000_0008` stable, `imem_addr = 12` stable, `fetch_count` unchanged. Release → next slot PC 12.
- **Redirect:** `redirect_pc = 32'h0000_0100` while slot PC 8 is being accepted → `fetch_count` increments, next cycle `out_valid = 0`, following cycle `out_pc = 32'h100`.
- **Misaligned redirect:** `redirect_pc = 32'h0000_0102` → `fault = 1`, `fault_pc = 32'h102`, `out_valid` stays 0 thereafter regardless of `fetch_en`/`out_ready`. `reset_n` pulse clears `fault`.
- **Wrap:** redirect to `32'hFFFF_FFFC` → slots at `32'hFFFF_FFFC` then `32'h0000_0000`, `out_pc_plus4 = 0` for the first, no fault.
- **Reset mid-stream and `fetch_en` gating:** assert `reset_n = 0` asynchronously mid-cycle → `out_valid` drops before the next edge. Then hold `fetch_en = 0` for 2 cycles → state IDLE, `out_valid = 0`; first `out_valid` one edge after `fetch_en` rises, `out_pc = RESET_PC`.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions.
// Holds the fetch FSM encoding and the basic machine widths.
package rv32_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, drives instruction memory and holds one
// registered fetch slot handed to decode over valid/ready.
module instruction_fetch
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rd_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [XLEN-1:0] fetch_count
);

    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;

    logic accept;
    logic redir_ok;
    logic redir_bad;
    logic do_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A redirect seen in IDLE retargets the PC but does not start fetching.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (redir_bad) begin
                    state_nxt = FAULT;
                end else if (!redirect_valid && fetch_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (redir_bad) begin
                    state_nxt = FAULT;
                end else if (!fetch_en) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept    = out_valid & out_ready;
        redir_ok  = 1'b0;
        redir_bad = 1'b0;
        do_load   = 1'b0;
        if (state != FAULT) begin
            if (redirect_valid) begin
                redir_ok  = (redirect_pc[1:0] == 2'b00);
                redir_bad = (redirect_pc[1:0] != 2'b00);
            end else if (fetch_en && (!out_valid || out_ready)) begin
                do_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            fault     <= 1'b0;
            fault_pc  <= '0;
        end else begin
            if (redir_bad) begin
                fault     <= 1'b1;
                fault_pc  <= redirect_pc;
                out_valid <= 1'b0;
            end else if (redir_ok) begin
                pc        <= redirect_pc;
                out_valid <= 1'b0;
            end else if (do_load) begin
                out_instr <= imem_rd_instr;
                out_pc    <= pc;
                pc        <= pc + STEP;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

    // The handshake still counts on the edge that takes a redirect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
        end else if (accept && state != FAULT) begin
            fetch_count <= fetch_count + 1'b1;
        end
    end

    assign imem_addr    = pc;
    assign out_pc_plus4 = out_pc + STEP;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a zero-latency memory
// model returning 32'hA000_0000 | addr.
module tb_instruction_fetch;

    logic        clk;
    logic        reset_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_rd_instr (imem_rd_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc_plus4  (out_pc_plus4),
        .fault         (fault),
        .fault_pc      (fault_pc),
        .fetch_count   (fetch_count)
    );

    assign imem_rd_instr = 32'hA000_0000 | imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %h want 0", out_valid);
        end
        n_checks++;
        if ({out_instr, out_pc, fault_pc, fetch_count} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_regs got %h %h %h %h want 0",
                     out_instr, out_pc, fault_pc, fetch_count);
        end
        n_checks++;
        if (out_pc_plus4 !== 32'h4 || fault !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_misc got p4=%h f=%h a=%h want 4 0 0",
                     out_pc_plus4, fault, imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) ||
                out_instr !== (32'hA000_0000 | 32'(4 * i)) ||
                fetch_count !== 32'(i)) begin
                n_fail++;
                $display("FAIL stream_%0d got v=%h pc=%h ins=%h cnt=%0d want pc=%0d cnt=%0d",
                         i, out_valid, out_pc, out_instr, fetch_count, 4 * i, i);
            end
        end
        step();
        n_checks++;
        if (fetch_count !== 32'd4 || out_pc !== 32'd16) begin
            n_fail++;
            $display("FAIL stream_count got cnt=%0d pc=%h want 4 10", fetch_count, out_pc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'd8 ||
                out_instr !== 32'hA000_0008 || imem_addr !== 32'd12 ||
                fetch_count !== 32'd2) begin
                n_fail++;
                $display("FAIL stall_%0d got v=%h pc=%h ins=%h a=%h cnt=%0d want 1 8 A0000008 c 2",
                         i, out_valid, out_pc, out_instr, imem_addr, fetch_count);
            end
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_pc !== 32'd12 || out_instr !== 32'hA000_000C || fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_release got pc=%h ins=%h cnt=%0d want c A000000C 3",
                     out_pc, out_instr, fetch_count);
        end
    endtask

    task automatic test_redirect_and_fault();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || fetch_count !== 32'd3 || imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_flush got v=%h cnt=%0d a=%h want 0 3 100",
                     out_valid, fetch_count, imem_addr);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'hA000_0100 ||
            fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL redirect_target got v=%h pc=%h ins=%h cnt=%0d want 1 100 A0000100 3",
                     out_valid, out_pc, out_instr, fetch_count);
        end
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || fault_pc !== 32'h102 || out_valid !== 1'b0 ||
            imem_addr !== 32'h104) begin
            n_fail++;
            $display("FAIL fault_entry got f=%h fpc=%h v=%h a=%h want 1 102 0 104",
                     fault, fault_pc, out_valid, imem_addr);
        end
        out_ready = 1'b1;
        fetch_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h104 ||
                fetch_count !== 32'd3) begin
                n_fail++;
                $display("FAIL fault_hold_%0d got f=%h v=%h a=%h cnt=%0d want 1 0 104 3",
                         i, fault, out_valid, imem_addr, fetch_count);
            end
        end
        reset_n = 1'b0;
        #2;
        n_checks++;
        if (fault !== 1'b0 || fault_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL fault_clear got f=%h fpc=%h want 0 0", fault, fault_pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        fetch_en       = 1'b1;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        n_checks++;
        if (imem_addr !== 32'hFFFF_FFFC || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_idle_redirect got a=%h v=%h want fffffffc 0", imem_addr, out_valid);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'h0 ||
            out_instr !== 32'hFFFF_FFFC || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_top got v=%h pc=%h p4=%h ins=%h f=%h want 1 fffffffc 0 fffffffc 0",
                     out_valid, out_pc, out_pc_plus4, out_instr, fault);
        end
        step();
        n_checks++;
        if (out_pc !== 32'h0 || out_instr !== 32'hA000_0000 || out_pc_plus4 !== 32'h4 ||
            fault !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_zero got pc=%h ins=%h p4=%h f=%h want 0 a0000000 4 0",
                     out_pc, out_instr, out_pc_plus4, fault);
        end
    endtask

    task automatic test_reset_mid_and_gating();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got v=%h pc=%h cnt=%0d want 0 0 0",
                     out_valid, out_pc, fetch_count);
        end
        fetch_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
                n_fail++;
                $display("FAIL gate_idle_%0d got v=%h a=%h want 0 0", i, out_valid, imem_addr);
            end
        end
        fetch_en = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin
            n_fail++;
            $display("FAIL gate_first got v=%h pc=%h ins=%h want 1 0 a0000000",
                     out_valid, out_pc, out_instr);
        end
        fetch_en = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || fetch_count !== 32'd1 || imem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL gate_drain got v=%h cnt=%0d a=%h want 0 1 4",
                     out_valid, fetch_count, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_and_fault();
        test_wrap();
        test_reset_mid_and_gating();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
